// File: rtl/oled_init_seq_if.sv
// Handshake bundle between the OLED power-up sequencer, its delay generator
// and its SPI byte shifter.
interface oled_init_seq_if;
    logic       delay_en;
    logic       delay_done;
    logic       spi_send;
    logic [7:0] spi_data;
    logic       spi_done;

    modport master (
        output delay_en,
        input  delay_done,
        output spi_send,
        output spi_data,
        input  spi_done
    );

    modport slave (
        input  delay_en,
        output delay_done,
        input  spi_send,
        input  spi_data,
        output spi_done
    );
endinterface

// File: rtl/oled_init_seq.sv
// OLED panel power-up sequencer: walks a fixed table of rail/reset pin moves,
// delay intervals and SPI command bytes, then parks in DONE until reset.
module oled_init_seq #(
    parameter int unsigned VBAT_DELAYS = 50
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    oled_init_seq_if.master bus,
    output logic oled_dc,
    output logic oled_res_n,
    output logic oled_vdd_n,
    output logic oled_vbat_n,
    output logic busy,
    output logic init_done
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DLY_WAIT, DLY_GAP, SPI_WAIT, SPI_GAP, DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_VDD_ON, OP_RES_LO, OP_RES_HI, OP_VBAT_ON, OP_DELAY, OP_SEND, OP_FINISH
    } op_t;

    state_t     state_q, state_d;
    logic [4:0] step_q, step_d;
    logic [6:0] rep_q, rep_d;
    logic       delay_en_q, delay_en_d;
    logic       spi_send_q, spi_send_d;
    logic [7:0] spi_data_q, spi_data_d;
    logic       res_n_q, res_n_d;
    logic       vdd_n_q, vdd_n_d;
    logic       vbat_n_q, vbat_n_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    op_t        op;
    logic [7:0] op_byte;
    logic [6:0] op_reps;

    // Step table: what the current step asks for. Repeat counts are "extra
    // intervals after the first", so a single interval loads zero.
    always_comb begin
        op      = OP_FINISH;
        op_byte = '0;
        op_reps = '0;
        case (step_q)
            5'd0:  op = OP_VDD_ON;
            5'd1:  op = OP_DELAY;
            5'd2:  begin op = OP_SEND; op_byte = 8'hAE; end
            5'd3:  op = OP_RES_LO;
            5'd4:  op = OP_DELAY;
            5'd5:  op = OP_RES_HI;
            5'd6:  op = OP_DELAY;
            5'd7:  begin op = OP_SEND; op_byte = 8'h8D; end
            5'd8:  begin op = OP_SEND; op_byte = 8'h14; end
            5'd9:  begin op = OP_SEND; op_byte = 8'hD9; end
            5'd10: begin op = OP_SEND; op_byte = 8'hF1; end
            5'd11: op = OP_VBAT_ON;
            5'd12: begin op = OP_DELAY; op_reps = 7'(VBAT_DELAYS - 1); end
            5'd13: begin op = OP_SEND; op_byte = 8'hA1; end
            5'd14: begin op = OP_SEND; op_byte = 8'hC8; end
            5'd15: begin op = OP_SEND; op_byte = 8'hDA; end
            5'd16: begin op = OP_SEND; op_byte = 8'h20; end
            5'd17: begin op = OP_SEND; op_byte = 8'hAF; end
            default: op = OP_FINISH;
        endcase
    end

    // Next-state and next-output logic; every output is produced as the
    // next value of its own register so nothing combinational reaches a pin.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        rep_d      = rep_q;
        delay_en_d = delay_en_q;
        spi_send_d = spi_send_q;
        spi_data_d = spi_data_q;
        res_n_d    = res_n_q;
        vdd_n_d    = vdd_n_q;
        vbat_n_d   = vbat_n_q;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    step_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                case (op)
                    OP_VDD_ON:  begin vdd_n_d  = 1'b0; step_d = step_q + 5'd1; end
                    OP_RES_LO:  begin res_n_d  = 1'b0; step_d = step_q + 5'd1; end
                    OP_RES_HI:  begin res_n_d  = 1'b1; step_d = step_q + 5'd1; end
                    OP_VBAT_ON: begin vbat_n_d = 1'b0; step_d = step_q + 5'd1; end
                    OP_DELAY: begin
                        rep_d      = op_reps;
                        delay_en_d = 1'b1;
                        state_d    = DLY_WAIT;
                    end
                    OP_SEND: begin
                        spi_data_d = op_byte;
                        spi_send_d = 1'b1;
                        state_d    = SPI_WAIT;
                    end
                    default: begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                endcase
            end
            DLY_WAIT: begin
                if (bus.delay_done) begin
                    delay_en_d = 1'b0;
                    state_d    = DLY_GAP;
                end
            end
            DLY_GAP: begin
                if (rep_q != '0) begin
                    rep_d      = rep_q - 7'd1;
                    delay_en_d = 1'b1;
                    state_d    = DLY_WAIT;
                end else begin
                    step_d  = step_q + 5'd1;
                    state_d = FETCH;
                end
            end
            SPI_WAIT: begin
                if (bus.spi_done) begin
                    spi_send_d = 1'b0;
                    state_d    = SPI_GAP;
                end
            end
            SPI_GAP: begin
                if (!bus.spi_done) begin
                    step_d  = step_q + 5'd1;
                    state_d = FETCH;
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and output registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            step_q     <= '0;
            rep_q      <= '0;
            delay_en_q <= 1'b0;
            spi_send_q <= 1'b0;
            spi_data_q <= '0;
            res_n_q    <= 1'b1;
            vdd_n_q    <= 1'b1;
            vbat_n_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            rep_q      <= rep_d;
            delay_en_q <= delay_en_d;
            spi_send_q <= spi_send_d;
            spi_data_q <= spi_data_d;
            res_n_q    <= res_n_d;
            vdd_n_q    <= vdd_n_d;
            vbat_n_q   <= vbat_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.delay_en = delay_en_q;
    assign bus.spi_send = spi_send_q;
    assign bus.spi_data = spi_data_q;
    assign oled_dc      = 1'b0;
    assign oled_res_n   = res_n_q;
    assign oled_vdd_n   = vdd_n_q;
    assign oled_vbat_n  = vbat_n_q;
    assign busy         = busy_q;
    assign init_done    = done_q;

endmodule
